// File: rtl/flopr_reg_pkg.sv
// Shared defaults for the flopr_reg register slice.
// Kept tiny on purpose: each instance still carries its own WIDTH/RESETVAL.
package flopr_reg_pkg;

    localparam int unsigned FLOPR_DEFAULT_WIDTH = 32'd8;

endpackage : flopr_reg_pkg

// File: rtl/flopr_bit.sv
// One-bit D flip-flop clocked on ph1 with asynchronous active-high reset.
// The reset value arrives as a port so the top can program each bit differently.
module flopr_bit (
    input  logic ph1,
    input  logic reset,
    input  logic resetval,
    input  logic d,
    output logic q
);

    // Capture d on each ph1 edge; reset forces the programmed value immediately.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            q <= resetval;
        end else begin
            q <= d;
        end
    end

endmodule : flopr_bit

// File: rtl/flopr_reg.sv
// Parameterized resettable D register built from WIDTH flopr_bit slices.
// ph2 exists only so this block drops into legacy two-phase netlists.
module flopr_reg
    import flopr_reg_pkg::*;
#(
    parameter int unsigned       WIDTH    = FLOPR_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]  RESETVAL = '0
) (
    input  logic             ph1,
    input  logic             ph2,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic unused_ph2;
    assign unused_ph2 = ph2;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        flopr_bit u_bit (
            .ph1      (ph1),
            .reset    (reset),
            .resetval (RESETVAL[i]),
            .d        (d[i]),
            .q        (q[i])
        );
    end

endmodule : flopr_reg

// File: tb/tb_flopr_reg.sv
// Self-checking bench for flopr_reg: a 2-bit FSM-style instance and a 32-bit
// instance with a non-zero reset value share ph1/ph2/reset.
module tb_flopr_reg;

    localparam logic [31:0] RV32 = 32'hDEADBEEF;

    logic        ph1 = 1'b0;
    logic        ph2 = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  d2 = 2'b00;
    logic [1:0]  q2;
    logic [31:0] d32 = 32'h0;
    logic [31:0] q32;

    logic [1:0]  exp2;
    logic [31:0] exp32;
    bit          valid = 1'b0;
    int          tests = 0;
    int          fails = 0;

    flopr_reg #(.WIDTH(2)) dut2 (
        .ph1(ph1), .ph2(ph2), .reset(reset), .d(d2), .q(q2)
    );

    flopr_reg #(.WIDTH(32), .RESETVAL(RV32)) dut32 (
        .ph1(ph1), .ph2(ph2), .reset(reset), .d(d32), .q(q32)
    );

    always #5 ph1 = ~ph1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Memory-FSM next state: 00 -> 01 -> 10 -> 00 when enabled.
    function automatic logic [1:0] fsm_next(input logic [1:0] s, input logic en);
        if (!en) return s;
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // Model: a register loads whatever d held at a ph1 edge unless reset is high.
    always @(posedge ph1) begin
        if (reset) begin
            exp2  = 2'b00;
            exp32 = RV32;
        end else begin
            exp2  = d2;
            exp32 = d32;
        end
    end

    task automatic assert_reset();
        reset = 1'b1;
        exp2  = 2'b00;
        exp32 = RV32;
    endtask

    // Every falling ph1 edge, once the model is defined, outputs must match it.
    always @(negedge ph1) begin
        if (valid) begin
            check("cycle_q2", {30'd0, q2}, {30'd0, exp2});
            check("cycle_q32", q32, exp32);
        end
    end

    logic [1:0] fsm_seq [3];

    initial begin
        fsm_seq[0] = 2'b01;
        fsm_seq[1] = 2'b10;
        fsm_seq[2] = 2'b00;

        // Asynchronous reset mid high phase, d=11 ignored.
        @(posedge ph1); #2;
        d2 = 2'b11;
        assert_reset();
        valid = 1'b1;
        #1;
        check("rst_async_q2", {30'd0, q2}, 32'd0);
        check("rst_async_q32", q32, 32'hDEADBEEF);
        @(posedge ph1); #1;
        check("rst_held_q2", {30'd0, q2}, 32'd0);

        // Release: value holds until the next ph1 edge, then loads.
        @(negedge ph1); #2;
        reset = 1'b0;
        #1;
        check("rst_release_hold", {30'd0, q2}, 32'd0);
        d2 = 2'b01; d32 = 32'h0;
        @(posedge ph1); #1;
        check("load_01", {30'd0, q2}, 32'd1);
        check("load32_zero", q32, 32'h0);
        @(negedge ph1); #2;
        d2 = 2'b10; d32 = 32'h12345678;
        @(posedge ph1); #1;
        check("load_10", {30'd0, q2}, 32'd2);
        check("load32_pattern", q32, 32'h12345678);

        // Reset coincident with a ph1 edge wins over d=11.
        @(negedge ph1); #2;
        d2 = 2'b11;
        @(posedge ph1);
        assert_reset();
        #1;
        check("rst_at_edge_q2", {30'd0, q2}, 32'd0);
        check("rst_at_edge_q32", q32, 32'hDEADBEEF);
        @(negedge ph1); #2;
        reset = 1'b0;

        // ph2 activity and d glitches between edges leave q alone.
        d2 = 2'b01;
        @(posedge ph1); #1;
        check("pre_glitch", {30'd0, q2}, 32'd1);
        ph2 = 1'b1; d2 = 2'b10; #1;
        ph2 = 1'b0; d2 = 2'b00; #1;
        ph2 = 1'bx; d2 = 2'b11; #1;
        check("glitch_hold_q2", {30'd0, q2}, 32'd1);
        ph2 = 1'b0;
        @(posedge ph1); #1;
        check("glitch_next_edge", {30'd0, q2}, 32'd3);

        // FSM loop fed from the modelled state.
        @(negedge ph1); #2;
        d2 = 2'b00;
        @(posedge ph1); #1;
        check("fsm_start", {30'd0, q2}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge ph1); #2;
            d2 = fsm_next(exp2, 1'b1);
            @(posedge ph1); #1;
            check("fsm_step", {30'd0, q2}, {30'd0, fsm_seq[i]});
        end
        @(negedge ph1); #2;
        d2 = fsm_next(exp2, 1'b0);
        @(posedge ph1); #1;
        check("fsm_disabled_hold", {30'd0, q2}, 32'd0);

        // X on d propagates; a following reset clears it.
        @(negedge ph1); #2;
        d2 = 2'bxx;
        @(posedge ph1); #1;
        check("x_propagates", {30'd0, q2}, {30'd0, 2'bxx});
        @(negedge ph1); #2;
        assert_reset();
        #1;
        check("x_cleared_by_rst", {30'd0, q2}, 32'd0);
        check("rst32_again", q32, 32'hDEADBEEF);
        @(negedge ph1); #2;
        reset = 1'b0;
        d32 = 32'h0;
        @(posedge ph1); #1;
        check("load32_after_rst", q32, 32'h0);

        // Random traffic checked by the per-cycle compare.
        for (int i = 0; i < 40; i++) begin
            @(negedge ph1); #2;
            d2  = 2'($urandom_range(0, 3));
            d32 = $urandom;
            ph2 = 1'($urandom_range(0, 1));
        end
        @(negedge ph1); #2;
        valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_flopr_reg
